// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; lw/sw go to a one-outstanding data bus, other ops pass through in one cycle.
// Latency 1 cycle (non-mem/misaligned), 1+N for memory; stall_o holds upstream during ACCESS; optional MEM_STAGE_TIMEOUT_EN abort.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [4:0]  ALUop_i,
  input  logic [31:0] ALUOut_i,
  input  logic [31:0] StoreData_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] WBData_o,
  output logic [4:0]  ALUop_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam logic [4:0] OP_LW = 5'b10100;
  localparam logic [4:0] OP_SW = 5'b10101;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        is_mem;
  logic        start;
  logic        retire;
  logic        ret_err;
  logic [31:0] ret_data;
  logic [4:0]  ret_op;
  logic [4:0]  op_q;
  logic        we_q;
  logic        expire;

  assign is_mem = (ALUop_i == OP_LW) || (ALUop_i == OP_SW);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt;

  // Expiry is judged on the value the counter would take at this edge.
  assign expire = ((cnt + 16'd1) == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (start) begin
      cnt <= 16'd0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    retire    = 1'b0;
    ret_err   = 1'b0;
    ret_data  = 32'd0;
    ret_op    = op_q;
    case (state)
      IDLE: begin
        if (valid_i) begin
          ret_op = ALUop_i;
          if (!is_mem) begin
            retire   = 1'b1;
            ret_data = ALUOut_i;
          end else if (ALUOut_i[1:0] != 2'b00) begin
            retire  = 1'b1;
            ret_err = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A ready on the expiry edge still completes normally.
        if (dmem_ready_i) begin
          retire    = 1'b1;
          state_nxt = IDLE;
          ret_data  = (op_q == OP_LW) ? dmem_rdata_i : 32'd0;
        end else if (expire) begin
          retire    = 1'b1;
          ret_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o      <= 1'b0;
      WBData_o     <= 32'd0;
      ALUop_o      <= 5'd0;
      err_o        <= 1'b0;
      op_q         <= 5'd0;
      we_q         <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
    end else begin
      valid_o <= retire;
      if (retire) begin
        WBData_o <= ret_data;
        ALUop_o  <= ret_op;
        err_o    <= ret_err;
      end
      if (start) begin
        op_q         <= ALUop_i;
        we_q         <= (ALUop_i == OP_SW);
        dmem_addr_o  <= ALUOut_i;
        dmem_wdata_o <= (ALUop_i == OP_SW) ? StoreData_i : 32'd0;
      end
    end
  end

  assign stall_o    = (state == ACCESS);
  assign dmem_req_o = (state == ACCESS);
  assign dmem_we_o  = (state == ACCESS) && we_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random instruction stream checked against a transaction-level model.
module tb_mem_stage;

  localparam logic [4:0] LW  = 5'b10100;
  localparam logic [4:0] SW  = 5'b10101;
  localparam logic [4:0] ADD = 5'b00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [4:0]  ALUop_i = 5'd0;
  logic [31:0] ALUOut_i = 32'd0;
  logic [31:0] StoreData_i = 32'd0;
  logic        stall_o, valid_o, err_o, dmem_req_o, dmem_we_o;
  logic [31:0] WBData_o, dmem_addr_o, dmem_wdata_o;
  logic [4:0]  ALUop_o;
  logic        dmem_ready_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'd0;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUop_i(ALUop_i),
    .ALUOut_i(ALUOut_i), .StoreData_i(StoreData_i), .stall_o(stall_o),
    .valid_o(valid_o), .WBData_o(WBData_o), .ALUop_o(ALUop_o), .err_o(err_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction; dly = ACCESS cycles before ready (memory ops only).
  task automatic run_instr(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [31:0] rd, input int dly, input logic idle_noise);
    logic        mem, bad;
    logic [31:0] exp_wb, exp_wd;
    mem    = (op == LW) || (op == SW);
    bad    = mem && (alu[1:0] != 2'b00);
    exp_wb = !mem ? alu : (bad ? 32'd0 : (op == LW ? rd : 32'd0));
    exp_wd = (op == SW) ? sd : 32'd0;
    valid_i = 1'b1; ALUop_i = op; ALUOut_i = alu; StoreData_i = sd;
    dmem_ready_i = idle_noise; dmem_rdata_i = $urandom;
    tick();
    valid_i = 1'b0; ALUop_i = 5'($urandom); ALUOut_i = $urandom; StoreData_i = $urandom;
    dmem_ready_i = 1'b0;
    if (mem && !bad) begin
      for (int c = 1; c <= dly; c++) begin
        chk("acc_stall", 32'(stall_o), 32'd1);
        chk("acc_req", 32'(dmem_req_o), 32'd1);
        chk("acc_addr", dmem_addr_o, alu);
        chk("acc_we", 32'(dmem_we_o), 32'(op == SW));
        chk("acc_wdata", dmem_wdata_o, exp_wd);
        chk("acc_valid", 32'(valid_o), 32'd0);
        if (c == dly) begin
          dmem_ready_i = 1'b1; dmem_rdata_i = rd;
        end
        tick();
        dmem_ready_i = 1'b0; dmem_rdata_i = $urandom;
      end
    end
    chk("ret_valid", 32'(valid_o), 32'd1);
    chk("ret_wb", WBData_o, exp_wb);
    chk("ret_err", 32'(err_o), 32'(bad));
    chk("ret_op", 32'(ALUop_o), 32'(op));
    chk("ret_stall", 32'(stall_o), 32'd0);
    chk("ret_req", 32'(dmem_req_o), 32'd0);
    tick();
    chk("pulse_end", 32'(valid_o), 32'd0);
    chk("hold_wb", WBData_o, exp_wb);
    chk("hold_err", 32'(err_o), 32'(bad));
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] alu;
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_wb", WBData_o, 32'd0);
    tick();
    rst_n = 1'b1;

    // add passthrough, lw with 3-cycle wait, sw with immediate ready, misaligned lw
    run_instr(ADD, 32'h0000_0123, 32'd0, 32'd0, 0, 1'b0);
    run_instr(LW, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 3, 1'b0);
    run_instr(SW, 32'h0000_0204, 32'h55AA_55AA, 32'h1234_5678, 1, 1'b0);
    run_instr(LW, 32'h0000_0102, 32'd0, 32'd0, 0, 1'b0);
    // ready asserted while idle must not disturb a non-memory op
    run_instr(5'b00011, 32'hCAFE_0001, 32'd0, 32'd0, 0, 1'b1);

`ifdef MEM_STAGE_TIMEOUT_EN
    valid_i = 1'b1; ALUop_i = LW; ALUOut_i = 32'h0000_0400;
    tick();
    valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("to_req", 32'(dmem_req_o), 32'd1);
      tick();
    end
    chk("to_req_drop", 32'(dmem_req_o), 32'd0);
    chk("to_valid", 32'(valid_o), 32'd1);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_wb", WBData_o, 32'd0);
    tick();
    run_instr(LW, 32'h0000_0408, 32'd0, 32'hA5A5_0F0F, 4, 1'b0);
`endif

    // random instruction stream
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: op = LW;
        1: op = SW;
        default: begin
          op = 5'($urandom);
          if (op == LW || op == SW) op = ADD;
        end
      endcase
      alu = $urandom;
      if ($urandom_range(0, 2) != 0) alu[1:0] = 2'b00;
      run_instr(op, alu, $urandom, $urandom, $urandom_range(1, 4), 1'($urandom));
    end

    // reset during ACCESS
    valid_i = 1'b1; ALUop_i = LW; ALUOut_i = 32'h0000_0300;
    tick();
    valid_i = 1'b0;
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_addr", dmem_addr_o, 32'd0);
    tick();
    rst_n = 1'b1;
    dmem_ready_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_valid", 32'(valid_o), 32'd0);
      chk("post_rst_stall", 32'(stall_o), 32'd0);
    end
    dmem_ready_i = 1'b0;
    run_instr(ADD, 32'h0000_0777, 32'd0, 32'd0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
